// File: rtl/fetch_queue_stage_pkg.sv
// Shared widths, constants and bus layouts for the fetch queue stage.
package fetch_queue_stage_pkg;

  localparam int          FS_TO_DS_BUS_W   = 64;
  localparam int          BR_ZIP_W         = 33;
  localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1C00_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_zip_t;

endpackage

// File: rtl/fetch_queue_stage_sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 mem_q <= '0;
    else if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: issues word fetches on a split req/resp bus,
// queues returned instructions and hands {inst, pc} to decode.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  output logic                      inst_sram_req,
  output logic                      inst_sram_wr,
  output logic [1:0]                inst_sram_size,
  output logic [31:0]               inst_sram_addr,
  output logic [31:0]               inst_sram_wdata,
  input  logic                      inst_sram_addr_ok,
  input  logic                      inst_sram_data_ok,
  input  logic [31:0]               inst_sram_rdata,
  input  logic                      ds_allowin,
  input  logic [BR_ZIP_W-1:0]       br_zip,
  output logic                      fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus
);

  localparam int QCW  = $clog2(QUEUE_DEPTH+1);
  localparam int ICW  = $clog2(MAX_OUTSTANDING+1);
  localparam int SUMW = QCW + ICW + 1;

  br_zip_t     br;
  fs_to_ds_t   q_wdata;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [ICW-1:0] discard_q, discard_d;
  logic [QCW-1:0] q_count;
  logic [ICW-1:0] inflight;
  logic [31:0] inflight_pc;
  logic [FS_TO_DS_BUS_W-1:0] q_head;
  logic        credit_ok, accept, rsp_keep, q_pop;

  assign br = br_zip_t'(br_zip);

  // Responses that will be discarded never land in the queue, so they do not
  // consume queue credit.
  assign credit_ok = (SUMW'(inflight) + SUMW'(q_count))
                   < (SUMW'(QUEUE_DEPTH) + SUMW'(discard_q));

  assign inst_sram_req   = resetn & ~br.taken
                         & (inflight < ICW'(MAX_OUTSTANDING)) & credit_ok;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SRAM_SIZE_WORD;
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wdata = 32'h0;

  assign accept   = inst_sram_req & inst_sram_addr_ok;
  assign rsp_keep = inst_sram_data_ok & ~br.taken & (discard_q == '0);
  assign q_pop    = fs_to_ds_valid & ds_allowin & ~br.taken;
  assign q_wdata  = '{inst: inst_sram_rdata, pc: inflight_pc};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (br.taken) begin
      fetch_pc_d = br.target;
      // Every response still owed after this cycle is stale; inflight already
      // covers earlier pending discards, so it is the whole new count.
      discard_d  = inflight - ICW'(inst_sram_data_ok);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (inst_sram_data_ok && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  // PCs of accepted requests; responses return in order, so the head pairs
  // with each data_ok whether it is kept or discarded.
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (inst_sram_data_ok),
    .flush_i (1'b0),
    .head_o  (inflight_pc),
    .count_o (inflight)
  );

  sync_fifo #(.WIDTH(FS_TO_DS_BUS_W), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (rsp_keep),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .flush_i (br.taken),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign fs_to_ds_valid = (q_count != '0);
  assign fs_to_ds_bus   = q_head;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench: behavioural instruction memory (rdata = ~addr) plus
// scenario tasks with hand-computed expectations.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        ds_allowin = 1'b0;
  logic [32:0] br_zip = '0;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;

  fetch_queue_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ds_allowin        (ds_allowin),
    .br_zip            (br_zip),
    .fs_to_ds_valid    (fs_to_ds_valid),
    .fs_to_ds_bus      (fs_to_ds_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int aok_mode = 0;
  int tb_inflight = 0;
  int max_inflight = 0;
  logic tog = 1'b0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_addr[$];
  int          acc_cyc[$];
  logic [63:0] out_bus[$];
  int          out_cyc[$];

  // Memory and monitor: sample on the rising edge, like a flop would.
  always @(posedge clk) begin
    pend_t p;
    cyc++;
    if (!resetn) begin
      pend.delete();
      tb_inflight = 0;
    end else begin
      if (inst_sram_data_ok) tb_inflight--;
      if (inst_sram_req && inst_sram_addr_ok) begin
        p.addr = inst_sram_addr;
        p.due  = cyc + lat - 1;
        pend.push_back(p);
        acc_addr.push_back(inst_sram_addr);
        acc_cyc.push_back(cyc);
        tb_inflight++;
      end
      if (tb_inflight > max_inflight) max_inflight = tb_inflight;
      if (fs_to_ds_valid && ds_allowin && !br_zip[32]) begin
        out_bus.push_back(fs_to_ds_bus);
        out_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    tog = ~tog;
    case (aok_mode)
      0:       inst_sram_addr_ok = 1'b1;
      1:       inst_sram_addr_ok = tog;
      default: inst_sram_addr_ok = 1'b0;
    endcase
    if (resetn && pend.size() > 0 && pend[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] pair(input logic [31:0] pc);
    return {~pc, pc};
  endfunction

  task automatic test_reset();
    ds_allowin = 1'b1; br_zip = '0; aok_mode = 0; lat = 1;
    step(3); #1;
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", inst_sram_req); end
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", fs_to_ds_valid); end
    total++; if (fs_to_ds_bus !== 64'h0) begin bad++; $display("FAIL reset_bus got=%h want=0", fs_to_ds_bus); end
    total++; if (inst_sram_addr !== 32'h1C00_0000) begin bad++; $display("FAIL reset_addr got=%h want=1c000000", inst_sram_addr); end
    total++; if ({inst_sram_wr, inst_sram_size, inst_sram_wdata} !== {1'b0, 2'b10, 32'h0}) begin
      bad++; $display("FAIL reset_consts got=%b/%b/%h want=0/10/0", inst_sram_wr, inst_sram_size, inst_sram_wdata); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc[3]   = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0008};
    logic [31:0] exp_inst[3] = '{32'hE3FF_FFFF, 32'hE3FF_FFFB, 32'hE3FF_FFF7};
    int ai = acc_addr.size();
    int oi = out_bus.size();
    resetn = 1'b1;
    step(10);
    total++;
    if (acc_addr.size() < ai + 3 || out_bus.size() < oi + 3) begin
      bad++; $display("FAIL stream_count got acc=%0d out=%0d want>=3 each", acc_addr.size() - ai, out_bus.size() - oi);
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++; if (acc_addr[ai+k] !== exp_pc[k]) begin bad++; $display("FAIL stream_addr%0d got=%h want=%h", k, acc_addr[ai+k], exp_pc[k]); end
        total++; if (acc_cyc[ai+k] != acc_cyc[ai] + k) begin bad++; $display("FAIL stream_acc_cyc%0d got=%0d want=%0d", k, acc_cyc[ai+k], acc_cyc[ai] + k); end
        total++; if (out_bus[oi+k] !== {exp_inst[k], exp_pc[k]}) begin bad++; $display("FAIL stream_out%0d got=%h want=%h", k, out_bus[oi+k], {exp_inst[k], exp_pc[k]}); end
        total++; if (out_cyc[oi+k] != acc_cyc[ai] + 2 + k) begin bad++; $display("FAIL stream_out_cyc%0d got=%0d want=%0d", k, out_cyc[oi+k], acc_cyc[ai] + 2 + k); end
      end
    end
  endtask

  task automatic test_backpressure();
    int oi;
    logic [31:0] last;
    ds_allowin = 1'b0;
    oi = out_bus.size();
    step(10); #1;
    total++; if (out_bus.size() != oi) begin bad++; $display("FAIL bp_no_pop got=%0d want=%0d", out_bus.size(), oi); end
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b want=0", inst_sram_req); end
    total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", fs_to_ds_valid); end
    total++; if (tb_inflight != 0) begin bad++; $display("FAIL bp_inflight got=%0d want=0", tb_inflight); end
    total++; if (acc_addr.size() - out_bus.size() != 4) begin bad++; $display("FAIL bp_queued got=%0d want=4", acc_addr.size() - out_bus.size()); end
    last = out_bus[oi-1][31:0];
    step(1);
    ds_allowin = 1'b1;
    step(8);
    total++;
    if (out_bus.size() < oi + 4) begin
      bad++; $display("FAIL bp_drain_count got=%0d want>=4", out_bus.size() - oi);
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (out_bus[oi+k] !== pair(last + 32'(4*(k+1)))) begin bad++; $display("FAIL bp_drain%0d got=%h want=%h", k, out_bus[oi+k], pair(last + 32'(4*(k+1)))); end
        total++; if (out_cyc[oi+k] != out_cyc[oi] + k) begin bad++; $display("FAIL bp_drain_cyc%0d got=%0d want=%0d", k, out_cyc[oi+k], out_cyc[oi] + k); end
      end
    end
  endtask

  task automatic test_outstanding();
    int oi;
    aok_mode = 1; lat = 4; max_inflight = 0;
    oi = out_bus.size();
    step(40);
    total++; if (max_inflight != 2) begin bad++; $display("FAIL os_max_inflight got=%0d want=2", max_inflight); end
    total++;
    if (out_bus.size() < oi + 6) begin
      bad++; $display("FAIL os_out_count got=%0d want>=6", out_bus.size() - oi);
    end else begin
      for (int k = 1; k < 6; k++) begin
        total++; if (out_bus[oi+k] !== pair(out_bus[oi+k-1][31:0] + 32'd4)) begin
          bad++; $display("FAIL os_order%0d got=%h want=%h", k, out_bus[oi+k], pair(out_bus[oi+k-1][31:0] + 32'd4)); end
      end
    end
  endtask

  task automatic test_redirect();
    int oi, ai;
    aok_mode = 0; lat = 20; ds_allowin = 1'b1;
    step(12); #1;
    total++; if (tb_inflight != 2) begin bad++; $display("FAIL redir_pre_inflight got=%0d want=2", tb_inflight); end
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL redir_pre_valid got=%b want=0", fs_to_ds_valid); end
    br_zip = {1'b1, 32'h1C00_0100};
    oi = out_bus.size(); ai = acc_addr.size();
    step(1);
    br_zip = '0; lat = 1;
    #1;
    total++; if (inst_sram_addr !== 32'h1C00_0100) begin bad++; $display("FAIL redir_addr got=%h want=1c000100", inst_sram_addr); end
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b want=0", fs_to_ds_valid); end
    for (int i = 0; i < 60 && out_bus.size() < oi + 2; i++) step(1);
    total++;
    if (out_bus.size() < oi + 2 || acc_addr.size() <= ai) begin
      bad++; $display("FAIL redir_timeout got=%0d want>=2 outputs", out_bus.size() - oi);
    end else begin
      total++; if (acc_addr[ai] !== 32'h1C00_0100) begin bad++; $display("FAIL redir_first_req got=%h want=1c000100", acc_addr[ai]); end
      total++; if (out_bus[oi] !== {32'hE3FF_FEFF, 32'h1C00_0100}) begin bad++; $display("FAIL redir_out0 got=%h want=e3fffeff1c000100", out_bus[oi]); end
      total++; if (out_bus[oi+1] !== {32'hE3FF_FEFB, 32'h1C00_0104}) begin bad++; $display("FAIL redir_out1 got=%h want=e3fffefb1c000104", out_bus[oi+1]); end
    end
  endtask

  task automatic test_redirect_collide();
    int oi, ai, rc;
    step(6);
    br_zip = {1'b1, 32'h1C00_0200};
    #1;
    total++; if ({inst_sram_data_ok, inst_sram_addr_ok} !== 2'b11) begin
      bad++; $display("FAIL coll_setup got=%b want=11", {inst_sram_data_ok, inst_sram_addr_ok}); end
    oi = out_bus.size(); ai = acc_addr.size();
    step(1);
    rc = cyc;
    br_zip = '0;
    #1;
    total++; if (acc_addr.size() != ai) begin bad++; $display("FAIL coll_no_accept got=%0d want=%0d", acc_addr.size(), ai); end
    total++; if (inst_sram_addr !== 32'h1C00_0200) begin bad++; $display("FAIL coll_addr got=%h want=1c000200", inst_sram_addr); end
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL coll_valid got=%b want=0", fs_to_ds_valid); end
    for (int i = 0; i < 20 && out_bus.size() < oi + 2; i++) step(1);
    total++;
    if (out_bus.size() < oi + 2) begin
      bad++; $display("FAIL coll_timeout got=%0d want>=2 outputs", out_bus.size() - oi);
    end else begin
      total++; if (out_bus[oi] !== {32'hE3FF_FDFF, 32'h1C00_0200}) begin bad++; $display("FAIL coll_out0 got=%h want=e3fffdff1c000200", out_bus[oi]); end
      total++; if (out_cyc[oi] - rc != 3) begin bad++; $display("FAIL coll_latency got=%0d want=3", out_cyc[oi] - rc); end
      total++; if (out_bus[oi+1] !== {32'hE3FF_FDFB, 32'h1C00_0204}) begin bad++; $display("FAIL coll_out1 got=%h want=e3fffdfb1c000204", out_bus[oi+1]); end
    end
  endtask

  task automatic test_reset_mid();
    int oi, ai;
    ds_allowin = 1'b0; lat = 1; aok_mode = 0;
    step(10);
    ds_allowin = 1'b1; lat = 20;
    step(2);
    ds_allowin = 1'b0;
    step(4); #1;
    total++; if (tb_inflight != 2) begin bad++; $display("FAIL rmid_pre_inflight got=%0d want=2", tb_inflight); end
    total++; if (fs_to_ds_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", fs_to_ds_valid); end
    resetn = 1'b0;
    #1;
    total++; if (fs_to_ds_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", fs_to_ds_valid); end
    total++; if (fs_to_ds_bus !== 64'h0) begin bad++; $display("FAIL rmid_bus got=%h want=0", fs_to_ds_bus); end
    total++; if (inst_sram_req !== 1'b0) begin bad++; $display("FAIL rmid_req got=%b want=0", inst_sram_req); end
    total++; if (inst_sram_addr !== 32'h1C00_0000) begin bad++; $display("FAIL rmid_addr got=%h want=1c000000", inst_sram_addr); end
    step(2);
    lat = 1; ds_allowin = 1'b1;
    ai = acc_addr.size(); oi = out_bus.size();
    resetn = 1'b1;
    step(6);
    total++;
    if (acc_addr.size() <= ai || out_bus.size() < oi + 2) begin
      bad++; $display("FAIL rmid_restart_count got acc=%0d out=%0d", acc_addr.size() - ai, out_bus.size() - oi);
    end else begin
      total++; if (acc_addr[ai] !== 32'h1C00_0000) begin bad++; $display("FAIL rmid_first_req got=%h want=1c000000", acc_addr[ai]); end
      total++; if (out_bus[oi] !== {32'hE3FF_FFFF, 32'h1C00_0000}) begin bad++; $display("FAIL rmid_out0 got=%h want=e3ffffff1c000000", out_bus[oi]); end
      total++; if (out_bus[oi+1] !== {32'hE3FF_FFFB, 32'h1C00_0004}) begin bad++; $display("FAIL rmid_out1 got=%h want=e3fffffb1c000004", out_bus[oi+1]); end
    end
  endtask

  initial begin
    resetn = 1'b1;
    #1 resetn = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_outstanding();
    test_redirect();
    test_redirect_collide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
